ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle control state machine sitting directly upstream of the 16-bit `ula`. It accepts one 16-bit instruction at a time over a valid/ready handshake, decodes it and drives the ALU function select (`ula_ctrl`, 3 bits), operand-source select, register-file read/write controls and a simple memory request/acknowledge interface. It signals completion with a one-cycle `done` pulse.

## Interface
- `IMM_W`, default 4: immediate field width. Fixed at 4 in this revision.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word.
  - Fields: `[15:12]` opcode, `[11:8]` rd, `[7:4]` rs, `[3:0]` rt/imm4.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  FSM can accept an instruction.
- `alu_out`  in  16  `ula` result, used only for the beq zero test.
- `mem_ack`  in  1  memory completed the current request.
- `ula_ctrl`  out  3  `ula` function select.
- `alu_src_imm`  out  1  0 selects `ula.in2` = rf read port 2; 1 selects zero-extended imm4.
- `imm`  out  16  zero-extended imm4.
- `rf_rd_addr1`, `rf_rd_addr2`  out  4 each  register-file read addresses.
- `rf_wr_addr`  out  4  write address.
- `rf_we`  out  1  register-file write enable.
- `rf_wr_sel`  out  1  write-data select: 0 = ALU result, 1 = memory data.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write; qualifies `mem_req`.
- `branch_taken`  out  1  one-cycle pulse: beq condition true.
- `done`  out  1  one-cycle pulse: instruction retired.
- `illegal`  out  1  one-cycle pulse: undefined opcode.

## Operation
- All outputs are registered.
- While `rst_n` is low, every output and the internal IR are 0 and the state is IDLE.
- Opcode map (opcode → ALU op):
  - 0 add, 1 sub, 2 or, 3 slt, 4 sll, 5 srl: R-type, rd = rs op rt, `ula_ctrl` = opcode[2:0].
  - 6 addi: rd = rs + imm4, ctrl 000.
  - 7 lw: rd = mem[rs + imm4], ctrl 000, `alu_src_imm` = 1.
  - 8 sw: mem[rs + imm4] = rd, ctrl 000, `alu_src_imm` = 1; `rf_rd_addr2` = rd supplies the store data.
  - 9 beq: branch if rd == rs; `rf_rd_addr1` = rd, `rf_rd_addr2` = rs, ctrl 001.
  - 10–15: illegal.
- IDLE: `instr_ready` = 1. When `instr_valid & instr_ready`, latch `instr` into IR, clear `instr_ready` and go to DECODE.
- DECODE, 1 cycle: drive the read addresses and `imm` from IR.
  - Illegal opcode → pulse `illegal`, return to IDLE. No `done`, no writes, no memory request.
  - Otherwise → EXEC.
- EXEC, 1 cycle: drive `ula_ctrl` and `alu_src_imm`.
  - R-type/addi → WB.
  - lw/sw → MEM.
  - beq: if `alu_out` == 16'h0000, pulse `branch_taken`; pulse `done` in the same cycle either way; → IDLE.
- MEM: hold `mem_req` = 1 (`mem_we` = 1 for sw) until the cycle `mem_ack` is sampled high. Then deassert both.
  - sw → pulse `done`, → IDLE.
  - lw → WB.
  - No timeout: the FSM waits indefinitely.
- WB, 1 cycle: `rf_we` = 1, `rf_wr_addr` = rd, `rf_wr_sel` = 1 for lw else 0; pulse `done`; → IDLE.
- Writes to r0 are issued normally; the register file decides whether to discard them.
- `mem_ack` outside MEM is ignored. `instr_valid` outside IDLE is ignored; the instruction is not captured.
- Reset asserted mid-instruction aborts immediately: all outputs return to 0 and no partial write is completed.

## Timing
- Handshake at edge 0 → DECODE at cycle 1 → EXEC at cycle 2.
- Retire cycle (`done`):
  - R-type/addi: cycle 3 (WB).
  - beq: cycle 2.
  - sw: the cycle after `mem_ack` is sampled.
  - lw: the WB cycle following that.
- `instr_ready` reasserts the cycle after `done` or `illegal`. Throughput: one R-type instruction per 4 cycles.
- `instr_ready` first rises on the first rising edge after `rst_n` deasserts.
- `mem_ack` in the first MEM cycle gives the minimum memory latency: sw retires at cycle 4, lw at cycle 5.
- Control outputs are stable for the full state they belong to. `ula` is combinational, so `alu_out` is valid within the EXEC cycle.

## Test plan
- Reset then idle: `rst_n` = 0 → all outputs 0. Release → `instr_ready` = 1 one edge later.
- add: `instr` = 16'h0312 (rd=3, rs=1, rt=2) with valid → `ula_ctrl` = 000 and `alu_src_imm` = 0 at cycle 2; `rf_we` = 1, `rf_wr_addr` = 3, `done` at cycle 3. Repeat for opcodes 1–5 and 6, checking `ula_ctrl` and the immediate select.
- lw with `mem_ack` delayed 3 cycles: 16'h7215 → `mem_req` held exactly 3 cycles, `mem_we` = 0, then WB with `rf_wr_sel` = 1 and `rf_wr_addr` = 2. sw 16'h8215 → `mem_we` = 1, `done`, no `rf_we`.
- beq 16'h9120: `alu_out` = 0 at EXEC → `branch_taken` and `done` at cycle 2. `alu_out` = 16'h0005 → `done` only.
- Illegal 16'hF000 → `illegal` pulse at cycle 1, no `done`/`rf_we`/`mem_req`; `instr_ready` = 1 at cycle 2.
- Reset during MEM wait → `mem_req` drops asynchronously, state IDLE. An `instr_valid` held during a busy instruction is not captured until IDLE.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM in front of the 16-bit ula: instruction handshake,
// decode, ALU/operand selects, register-file and memory request sequencing.
module ctrl_fsm #(
    parameter int IMM_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [15:0] alu_out_i,
    input  logic        mem_ack_i,
    output logic [2:0]  ula_ctrl_o,
    output logic        alu_src_imm_o,
    output logic [15:0] imm_o,
    output logic [3:0]  rf_rd_addr1_o,
    output logic [3:0]  rf_rd_addr2_o,
    output logic [3:0]  rf_wr_addr_o,
    output logic        rf_we_o,
    output logic        rf_wr_sel_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        branch_taken_o,
    output logic        done_o,
    output logic        illegal_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_MACK, S_WB
    } state_t;

    typedef struct packed {
        logic        instr_ready;
        logic [2:0]  ula_ctrl;
        logic        alu_src_imm;
        logic [15:0] imm;
        logic [3:0]  rd_addr1;
        logic [3:0]  rd_addr2;
        logic [3:0]  wr_addr;
        logic        we;
        logic        wr_sel;
        logic        mem_req;
        logic        mem_we;
        logic        done;
        logic        illegal;
        logic        beq_exec;
    } outs_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    outs_t       o_q, o_d;
    logic        accept;
    logic [3:0]  op, rd, rs, rt;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_ill;

    assign accept = (state_q == S_IDLE) && instr_valid_i && o_q.instr_ready;
    assign ir_d   = accept ? instr_i : ir_q;

    assign op = ir_d[15:12];
    assign rd = ir_d[11:8];
    assign rs = ir_d[7:4];
    assign rt = ir_d[3:0];

    assign is_r    = (op <= 4'd5);
    assign is_addi = (op == 4'd6);
    assign is_lw   = (op == 4'd7);
    assign is_sw   = (op == 4'd8);
    assign is_beq  = (op == 4'd9);
    assign is_ill  = (op >= 4'd10);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = is_ill ? S_IDLE : S_EXEC;
            S_EXEC: begin
                if (is_lw || is_sw) state_d = S_MEM;
                else if (is_beq)    state_d = S_IDLE;
                else                state_d = S_WB;
            end
            S_MEM:    if (mem_ack_i) state_d = S_MACK;
            S_MACK:   state_d = is_lw ? S_WB : S_IDLE;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are computed for the state being entered so the registered
        // copy lines up exactly with that state.
        o_d = '0;
        o_d.instr_ready = (state_d == S_IDLE);
        if (state_d != S_IDLE) begin
            o_d.rd_addr1 = is_beq ? rd : rs;
            o_d.rd_addr2 = is_beq ? rs : (is_sw ? rd : rt);
            o_d.imm      = {{(16-IMM_W){1'b0}}, ir_d[IMM_W-1:0]};
        end
        if (state_d == S_EXEC || state_d == S_MEM) begin
            o_d.ula_ctrl    = is_r ? op[2:0] : (is_beq ? 3'b001 : 3'b000);
            o_d.alu_src_imm = is_addi || is_lw || is_sw;
        end
        if (state_d == S_MEM) begin
            o_d.mem_req = 1'b1;
            o_d.mem_we  = is_sw;
        end
        if (state_d == S_WB) begin
            o_d.we      = 1'b1;
            o_d.wr_addr = rd;
            o_d.wr_sel  = is_lw;
        end
        o_d.done     = (state_d == S_WB) || (state_d == S_EXEC && is_beq) ||
                       (state_d == S_MACK && is_sw);
        o_d.illegal  = (state_d == S_DECODE) && is_ill;
        o_d.beq_exec = (state_d == S_EXEC) && is_beq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            o_q     <= o_d;
        end
    end

    assign instr_ready_o = o_q.instr_ready;
    assign ula_ctrl_o    = o_q.ula_ctrl;
    assign alu_src_imm_o = o_q.alu_src_imm;
    assign imm_o         = o_q.imm;
    assign rf_rd_addr1_o = o_q.rd_addr1;
    assign rf_rd_addr2_o = o_q.rd_addr2;
    assign rf_wr_addr_o  = o_q.wr_addr;
    assign rf_we_o       = o_q.we;
    assign rf_wr_sel_o   = o_q.wr_sel;
    assign mem_req_o     = o_q.mem_req;
    assign mem_we_o      = o_q.mem_we;
    assign done_o        = o_q.done;
    assign illegal_o     = o_q.illegal;
    // alu_out only settles inside EXEC, so the zero test is gated by a
    // registered EXEC-of-beq flag rather than registered itself.
    assign branch_taken_o = o_q.beq_exec && (alu_out_i == 16'h0000);

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: stimulus pushes hand-computed expectations,
// a monitor collects each instruction's behaviour and compares at retire.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] alu_out = 16'h0001;
    logic        mem_ack = 1'b0;
    logic [2:0]  ula_ctrl;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic        rf_we, rf_wr_sel, mem_req, mem_we, branch_taken, done, illegal;

    ctrl_fsm #(.IMM_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_i(instr), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .alu_out_i(alu_out), .mem_ack_i(mem_ack),
        .ula_ctrl_o(ula_ctrl), .alu_src_imm_o(alu_src_imm), .imm_o(imm),
        .rf_rd_addr1_o(rf_rd_addr1), .rf_rd_addr2_o(rf_rd_addr2), .rf_wr_addr_o(rf_wr_addr),
        .rf_we_o(rf_we), .rf_wr_sel_o(rf_wr_sel), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .branch_taken_o(branch_taken), .done_o(done), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int ctrl, simm, lat, ill, br, we, waddr, wsel, memcyc, mwe, ra1, ra2, immv;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_pass = 0;
    int   ack_delay = 1;
    bit   m_active = 0, m_post = 0;
    int   gcyc = 0, hs_cur = 0, hs_prev = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // -1 in ra1/ra2/immv means "not checked for this instruction".
    function automatic exp_t mk(input logic [15:0] w, input int ctrl, simm, lat, ill, br,
                                we, waddr, wsel, memcyc, mwe, ra1, ra2, immv);
        exp_t e;
        e.w = w; e.ctrl = ctrl; e.simm = simm; e.lat = lat; e.ill = ill; e.br = br;
        e.we = we; e.waddr = waddr; e.wsel = wsel; e.memcyc = memcyc; e.mwe = mwe;
        e.ra1 = ra1; e.ra2 = ra2; e.immv = immv;
        return e;
    endfunction

    // Memory model: ack goes high in the ack_delay-th cycle of a request.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                cnt++;
                mem_ack = (cnt == ack_delay);
            end else begin
                cnt = 0;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        int cyc, mcyc, mwe_s, we_cnt, wa, ws, ctrl, simm, ra1, ra2, immv, rdy_busy;
        exp_t e;
        string p;
        forever begin
            @(negedge clk);
            gcyc++;
            if (!rst_n) begin
                m_active = 0;
                m_post = 0;
                continue;
            end
            if (m_post) begin
                chk("ready_after_retire", int'(instr_ready), 1);
                chk("pulse_width", int'(done | illegal), 0);
                m_post = 0;
            end
            if (m_active) begin
                cyc++;
                if (cyc == 1) begin ra1 = rf_rd_addr1; ra2 = rf_rd_addr2; immv = imm; end
                if (cyc == 2) begin ctrl = ula_ctrl; simm = alu_src_imm; end
                if (mem_req) mcyc++;
                if (mem_we) mwe_s = 1;
                if (rf_we) begin we_cnt++; wa = rf_wr_addr; ws = rf_wr_sel; end
                if (instr_ready) rdy_busy++;
                if (done || illegal) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_retire: got retire at cycle %0d expected none", cyc);
                    end else begin
                        e = sbq.pop_front();
                        p = $sformatf("%h_", e.w);
                        chk({p, "latency"}, cyc, e.lat);
                        chk({p, "illegal"}, int'(illegal), e.ill);
                        chk({p, "done"}, int'(done), e.ill == 0 ? 1 : 0);
                        chk({p, "branch_taken"}, int'(branch_taken), e.br);
                        chk({p, "rf_we_cycles"}, we_cnt, e.we);
                        if (e.we != 0) begin
                            chk({p, "rf_wr_addr"}, wa, e.waddr);
                            chk({p, "rf_wr_sel"}, ws, e.wsel);
                        end
                        chk({p, "mem_req_cycles"}, mcyc, e.memcyc);
                        chk({p, "mem_we"}, mwe_s, e.mwe);
                        if (e.ill == 0) begin
                            chk({p, "ula_ctrl"}, ctrl, e.ctrl);
                            chk({p, "alu_src_imm"}, simm, e.simm);
                        end
                        if (e.ra1 >= 0) chk({p, "rf_rd_addr1"}, ra1, e.ra1);
                        if (e.ra2 >= 0) chk({p, "rf_rd_addr2"}, ra2, e.ra2);
                        if (e.immv >= 0) chk({p, "imm"}, immv, e.immv);
                        chk({p, "ready_while_busy"}, rdy_busy, 0);
                    end
                    m_active = 0;
                    m_post = 1;
                end else if (cyc > 60) begin
                    n_chk++;
                    $display("FAIL retire_timeout: got no retire after %0d cycles expected one", cyc);
                    m_active = 0;
                end
            end
            if (!m_active && instr_ready && instr_valid) begin
                m_active = 1;
                cyc = 0; mcyc = 0; mwe_s = 0; we_cnt = 0; wa = 0; ws = 0;
                ctrl = 0; simm = 0; ra1 = 0; ra2 = 0; immv = 0; rdy_busy = 0;
                hs_prev = hs_cur;
                hs_cur = gcyc;
            end
        end
    end

    task automatic send(input logic [15:0] w, input exp_t e, input bit hold);
        int n;
        @(posedge clk); #1;
        sbq.push_back(e);
        instr = w;
        instr_valid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        if (n == 100) begin
            n_chk++;
            $display("FAIL handshake_timeout: got no instr_ready for %h expected ready", w);
        end
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0 && !m_active && !m_post) break;
        end
        if (n == 200) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
    endtask

    function automatic int ctl_outs();
        return int'({ula_ctrl, alu_src_imm, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_we,
                     rf_wr_sel, mem_req, mem_we, branch_taken, done, illegal, instr_ready});
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] w;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl_outs", ctl_outs(), 0);
        chk("reset_imm", int'(imm), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", int'(instr_ready), 0);
        @(posedge clk); #1;
        chk("ready_first_edge", int'(instr_ready), 1);

        // R-type opcodes 0..5 on rd=3, rs=1, rt=2
        for (int op = 0; op < 6; op++) begin
            w = {op[3:0], 12'h312};
            send(w, mk(w, op, 0, 3, 0, 0, 1, 3, 0, 0, 0, 1, 2, -1), 0);
            drain();
        end
        send(16'h6317, mk(16'h6317, 0, 1, 3, 0, 0, 1, 3, 0, 0, 0, 1, -1, 7), 0);
        drain();

        ack_delay = 3;
        send(16'h7215, mk(16'h7215, 0, 1, 7, 0, 0, 1, 2, 1, 3, 0, 1, -1, 5), 0);
        drain();
        ack_delay = 1;
        send(16'h8215, mk(16'h8215, 0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 1, 2, 5), 0);
        drain();
        send(16'h7215, mk(16'h7215, 0, 1, 5, 0, 0, 1, 2, 1, 1, 0, 1, -1, 5), 0);
        drain();

        alu_out = 16'h0000;
        send(16'h9120, mk(16'h9120, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 1, 2, -1), 0);
        drain();
        alu_out = 16'h0005;
        send(16'h9120, mk(16'h9120, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, -1), 0);
        drain();
        alu_out = 16'h0001;

        send(16'hF000, mk(16'hF000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, -1, -1, -1), 0);
        drain();
        send(16'hA000, mk(16'hA000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, -1, -1, -1), 0);
        drain();

        // valid held through a busy add with a different word presented
        send(16'h0312, mk(16'h0312, 0, 0, 3, 0, 0, 1, 3, 0, 0, 0, 1, 2, -1), 1);
        instr = 16'h6A1F;
        send(16'h6A1F, mk(16'h6A1F, 0, 1, 3, 0, 0, 1, 10, 0, 0, 0, 1, -1, 15), 0);
        drain();
        chk("throughput_gap", hs_cur - hs_prev, 4);

        // reset while waiting on memory
        ack_delay = 50;
        @(posedge clk); #1;
        instr = 16'h7215;
        instr_valid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("abort_mem_req_seen", int'(mem_req), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req_drop", int'(mem_req), 0);
        chk("abort_ctl_outs", ctl_outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_low", int'(instr_ready), 0);
        @(posedge clk); #1;
        chk("abort_idle_ready", int'(instr_ready), 1);
        ack_delay = 1;
        send(16'h1312, mk(16'h1312, 1, 0, 3, 0, 0, 1, 3, 0, 0, 0, 1, 2, -1), 0);
        drain();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
